spi_wb_xfer_ctrl: RTL and testbench
===================================

// Module: spi_wb_xfer_ctrl
// PURPOSE
//  Synthesizable Wishbone master sequencer that runs one SPI byte transfer through the SPI master's register port.
//  On a single request it optionally programs divider and control, writes TX data, polls status until done, then reads RX data.
//  Sits between on-chip client logic and the SPI master Wishbone slave, replacing per-access software/bench sequencing.
// PARAMETERS
//  DATA_WIDTH   8   Wishbone data width; also request/response width
//  ADR_WIDTH    32  Wishbone address width
//  CTRL_ADR     0   control register address
//  DIV_ADR      1   clock divider register address
//  TXD_ADR      2   TX data register address
//  RXD_ADR      3   RX data register address
//  STAT_ADR     4   status register address
//  DONE_BIT     0   bit of status word; 1 = transfer complete
//  ACK_TIMEOUT  16  max cycles stb may wait for ack before abort
//  POLL_MAX     255 max status reads per transfer before abort
// PORTS
//  clk       in   1           system clock
//  rst       in   1           synchronous active-high reset
//  req       in   1           start transfer; sampled only when busy=0
//  req_cfg   in   1           1: write DIV then CTRL before TXD
//  req_data  in   DATA_WIDTH  byte to transmit
//  cfg_div   in   DATA_WIDTH  divider value (used when req_cfg=1)
//  cfg_ctrl  in   DATA_WIDTH  control value (used when req_cfg=1)
//  busy      out  1           transfer in progress
//  done      out  1           1-cycle pulse: transfer completed, rsp_data valid
//  err       out  1           1-cycle pulse: ack timeout or poll limit hit
//  rsp_data  out  DATA_WIDTH  received byte, held until next done
//  stb       out  1           Wishbone strobe
//  we        out  1           Wishbone write enable
//  adr       out  ADR_WIDTH   Wishbone address
//  dout      out  DATA_WIDTH  Wishbone write data
//  din       in   DATA_WIDTH  Wishbone read data
//  ack       in   1           Wishbone acknowledge
// BEHAVIOUR
//  Reset (sync, any state): stb=we=0, adr=0, dout=0, busy=done=err=0, rsp_data=0, counters=0, state=IDLE.
//  All outputs registered. adr/dout driven 0 whenever stb=0 (never X).
//  FSM: IDLE -> [W_DIV -> W_CTRL ->] W_TXD -> R_STAT -> R_RXD -> IDLE; GAP state between every pair of accesses.
//  IDLE: req=1 at edge -> latch req_cfg/req_data/cfg_*; busy=1 next cycle, stb=1 for first access same cycle.
//  req while busy=1: ignored, not queued.
//  Access state: stb=1, we/adr/dout constant until ack sampled 1 at posedge; that edge drops stb, enters GAP.
//  GAP: exactly one cycle stb=0, then next access asserts stb.
//  Min access = 2 cycles (stb + gap) with a 1-cycle-ack slave.
//  R_STAT: on ack, din[DONE_BIT]=1 -> R_RXD; else poll count +1 and re-read STAT after GAP.
//  R_RXD: on ack, rsp_data<=din; done=1 for one cycle; busy=0 same cycle; state=IDLE.
//  New req accepted the cycle after done.
//  Ack timeout: counter cleared at each stb rise, +1 per cycle with stb=1 and ack=0.
//  Reaching ACK_TIMEOUT: stb=0, err=1 one cycle, busy=0, IDLE; rsp_data unchanged.
//  Poll limit: POLL_MAX status reads with DONE_BIT=0 -> err pulse, IDLE, no RXD read.
//  ack while stb=0: ignored. done and err never in the same cycle.
// TESTING
//  1. req_cfg=1, data=A5, div=04, ctrl=C1, 1-cycle ack, status done first read, RXD=3C.
//     Writes adr1=04, adr0=C1, adr2=A5; reads 4 then 3; done pulse; rsp_data=3C; total 10 cycles req->done.
//  2. req_cfg=0, data=5A -> only W 2=5A, R 4, R 3 issued; no DIV/CTRL write; done pulse once.
//  3. Status DONE_BIT=0 for 3 reads then 1 -> exactly 4 STAT reads each separated by 1 idle cycle, then RXD read, done.
//  4. Slave never acks W_TXD -> stb high exactly 16 cycles, then stb=0, err pulse, busy=0; next req runs normally.
//  5. Status never done, POLL_MAX=4 -> 4 STAT reads, err pulse, no adr3 access; pulse req during busy -> no extra transfer.
//  6. Assert rst for 1 cycle mid W_CTRL with stb=1 -> next edge stb=0, adr=0, busy=0, state IDLE; later req completes.

Source files
------------

// File: rtl/spi_wb_xfer_ctrl.sv
// Wishbone master sequencer for one SPI byte transfer: optional DIV/CTRL setup,
// TXD write, STAT polling until done, then RXD read.
module spi_wb_xfer_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADR_WIDTH   = 32,
  parameter int CTRL_ADR    = 0,
  parameter int DIV_ADR     = 1,
  parameter int TXD_ADR     = 2,
  parameter int RXD_ADR     = 3,
  parameter int STAT_ADR    = 4,
  parameter int DONE_BIT    = 0,
  parameter int ACK_TIMEOUT = 16,
  parameter int POLL_MAX    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  req_cfg,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [DATA_WIDTH-1:0] cfg_div,
  input  logic [DATA_WIDTH-1:0] cfg_ctrl,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  stb,
  output logic                  we,
  output logic [ADR_WIDTH-1:0]  adr,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  ack
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  typedef enum logic [2:0] {IDLE, W_DIV, W_CTRL, W_TXD, R_STAT, R_RXD, GAP} state_t;

  state_t                state, state_n, pend, pend_n;
  logic [DATA_WIDTH-1:0] div_q, ctrl_q, txd_q;
  logic                  stb_n, we_n, busy_n, done_n, err_n;
  logic [ADR_WIDTH-1:0]  adr_n;
  logic [DATA_WIDTH-1:0] dout_n, rsp_n;
  logic [TW-1:0]         tmo, tmo_n;
  logic [PW-1:0]         poll, poll_n;

  // Launch target: in IDLE the request inputs are used directly since the
  // latched copies only become valid at the same edge.
  state_t                l_state;
  logic                  l_we;
  logic [ADR_WIDTH-1:0]  l_adr;
  logic [DATA_WIDTH-1:0] l_dout;
  logic [DATA_WIDTH-1:0] s_div, s_ctrl, s_txd;

  always_comb begin
    l_state = (state == IDLE) ? (req_cfg ? W_DIV : W_TXD) : pend;
    s_div   = (state == IDLE) ? cfg_div  : div_q;
    s_ctrl  = (state == IDLE) ? cfg_ctrl : ctrl_q;
    s_txd   = (state == IDLE) ? req_data : txd_q;
    l_we    = 1'b0;
    l_adr   = '0;
    l_dout  = '0;
    case (l_state)
      W_DIV:  begin l_we = 1'b1; l_adr = ADR_WIDTH'(DIV_ADR);  l_dout = s_div;  end
      W_CTRL: begin l_we = 1'b1; l_adr = ADR_WIDTH'(CTRL_ADR); l_dout = s_ctrl; end
      W_TXD:  begin l_we = 1'b1; l_adr = ADR_WIDTH'(TXD_ADR);  l_dout = s_txd;  end
      R_STAT: l_adr = ADR_WIDTH'(STAT_ADR);
      R_RXD:  l_adr = ADR_WIDTH'(RXD_ADR);
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    pend_n  = pend;
    stb_n   = stb;
    we_n    = we;
    adr_n   = adr;
    dout_n  = dout;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    rsp_n   = rsp_data;
    tmo_n   = tmo;
    poll_n  = poll;
    unique case (state)
      IDLE, GAP: begin
        if (state == GAP || req) begin
          state_n = l_state;
          stb_n   = 1'b1;
          we_n    = l_we;
          adr_n   = l_adr;
          dout_n  = l_dout;
          busy_n  = 1'b1;
          tmo_n   = '0;
          if (state == IDLE) poll_n = '0;
        end
      end
      default: begin
        if (ack) begin
          stb_n   = 1'b0;
          we_n    = 1'b0;
          adr_n   = '0;
          dout_n  = '0;
          state_n = GAP;
          case (state)
            W_DIV:  pend_n = W_CTRL;
            W_CTRL: pend_n = W_TXD;
            W_TXD:  pend_n = R_STAT;
            R_STAT: begin
              if (din[DONE_BIT]) begin
                pend_n = R_RXD;
              end else if (poll == POLL_LAST) begin
                state_n = IDLE;
                busy_n  = 1'b0;
                err_n   = 1'b1;
              end else begin
                poll_n = poll + 1'b1;
                pend_n = R_STAT;
              end
            end
            R_RXD: begin
              rsp_n   = din;
              done_n  = 1'b1;
              busy_n  = 1'b0;
              state_n = IDLE;
            end
            default: ;
          endcase
        end else if (tmo == TMO_LAST) begin
          // Slave stalled too long: abandon the transfer, keep last rsp_data.
          stb_n   = 1'b0;
          we_n    = 1'b0;
          adr_n   = '0;
          dout_n  = '0;
          busy_n  = 1'b0;
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= IDLE;
      stb      <= 1'b0;
      we       <= 1'b0;
      adr      <= '0;
      dout     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rsp_data <= '0;
      tmo      <= '0;
      poll     <= '0;
      div_q    <= '0;
      ctrl_q   <= '0;
      txd_q    <= '0;
    end else begin
      state    <= state_n;
      pend     <= pend_n;
      stb      <= stb_n;
      we       <= we_n;
      adr      <= adr_n;
      dout     <= dout_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      rsp_data <= rsp_n;
      tmo      <= tmo_n;
      poll     <= poll_n;
      if (state == IDLE && req) begin
        div_q  <= cfg_div;
        ctrl_q <= cfg_ctrl;
        txd_q  <= req_data;
      end
    end
  end

endmodule

// File: tb/tb_spi_wb_xfer_ctrl.sv
// Bench for spi_wb_xfer_ctrl: scripted Wishbone slave plus a transaction-level
// model that expands each planned transfer into the expected per-cycle outputs.
module tb_spi_wb_xfer_ctrl;
  localparam int TMO  = 16;
  localparam int PMAX = 4;

  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, req_cfg = 1'b0;
  logic [7:0]  req_data = '0, cfg_div = '0, cfg_ctrl = '0;
  logic        busy, done, err, stb, we, ack;
  logic [7:0]  rsp_data, dout, din;
  logic [31:0] adr;

  always #5 clk = ~clk;

  spi_wb_xfer_ctrl #(.POLL_MAX(PMAX)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cfg(req_cfg), .req_data(req_data),
    .cfg_div(cfg_div), .cfg_ctrl(cfg_ctrl), .busy(busy), .done(done), .err(err),
    .rsp_data(rsp_data), .stb(stb), .we(we), .adr(adr), .dout(dout),
    .din(din), .ack(ack)
  );

  int vecs = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Slave plan for the current transfer
  logic       p_cfg = 1'b0, p_spur = 1'b0;
  logic [7:0] p_data = '0, p_div = '0, p_ctrl = '0, p_rx = '0, p_junk = 8'h5e;
  int         p_notdone = 0;
  int         p_delay[16];
  int         hold_cnt = 0, acc_idx = 0, stat_idx = 0;
  logic [16:0] blog[$];

  always_comb begin
    ack = p_spur;
    din = p_junk;
    if (stb) begin
      ack = (hold_cnt == p_delay[acc_idx]);
      if (adr == 32'd4)      din = {p_junk[7:1], stat_idx >= p_notdone};
      else if (adr == 32'd3) din = p_rx;
    end
  end

  always @(posedge clk) begin
    if (!busy && !stb) begin
      acc_idx  <= 0;
      stat_idx <= 0;
    end else if (stb && ack) begin
      acc_idx <= acc_idx + 1;
      if (adr == 32'd4) stat_idx <= stat_idx + 1;
      blog.push_back({we, adr[7:0], we ? dout : 8'h00});
    end
    hold_cnt <= (stb && !ack) ? hold_cnt + 1 : 0;
  end

  // Transaction-level model
  typedef struct packed {
    logic stb, we; logic [31:0] adr; logic [7:0] dout;
    logic busy, done, err; logic [7:0] rsp;
  } exp_t;
  exp_t q[$];
  logic [7:0] mrsp = '0;

  function automatic exp_t mk(logic s, logic w, logic [31:0] a, logic [7:0] d,
                              logic b, logic dn, logic e, logic [7:0] r);
    exp_t x;
    x.stb = s; x.we = w; x.adr = a; x.dout = d;
    x.busy = b; x.done = dn; x.err = e; x.rsp = r;
    return x;
  endfunction

  task automatic gen();
    logic [7:0] a_adr[16], a_dout[16];
    logic       a_we[16];
    int n, nstat, h;
    bit pabort;
    n = 0;
    if (p_cfg) begin
      a_we[n] = 1; a_adr[n] = 8'd1; a_dout[n] = p_div;  n++;
      a_we[n] = 1; a_adr[n] = 8'd0; a_dout[n] = p_ctrl; n++;
    end
    a_we[n] = 1; a_adr[n] = 8'd2; a_dout[n] = p_data; n++;
    pabort = (p_notdone >= PMAX);
    nstat  = pabort ? PMAX : p_notdone + 1;
    for (int k = 0; k < nstat; k++) begin a_we[n] = 0; a_adr[n] = 8'd4; a_dout[n] = 0; n++; end
    if (!pabort) begin a_we[n] = 0; a_adr[n] = 8'd3; a_dout[n] = 0; n++; end
    for (int i = 0; i < n; i++) begin
      h = (p_delay[i] >= TMO) ? TMO : p_delay[i] + 1;
      repeat (h) q.push_back(mk(1, a_we[i], 32'(a_adr[i]), a_dout[i], 1, 0, 0, mrsp));
      if (p_delay[i] >= TMO) begin
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, mrsp));
        return;
      end
      if (i == n - 1) begin
        if (pabort) q.push_back(mk(0, 0, 0, 0, 0, 0, 1, mrsp));
        else begin
          mrsp = p_rx;
          q.push_back(mk(0, 0, 0, 0, 0, 1, 0, mrsp));
        end
      end else begin
        q.push_back(mk(0, 0, 0, 0, 1, 0, 0, mrsp));
      end
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e = (q.size() > 0) ? q.pop_front() : mk(0, 0, 0, 0, 0, 0, 0, mrsp);
      chk("cycle", {stb, we, adr, dout, busy, done, err, rsp_data}, e);
    end
  end

  // Caller is at negedge+1; request is sampled at the next posedge.
  task automatic start(input bit cfg, input logic [7:0] data, div, ctrl);
    blog.delete();
    p_cfg = cfg; p_data = data; p_div = div; p_ctrl = ctrl;
    gen();
    req = 1; req_cfg = cfg; req_data = data; cfg_div = div; cfg_ctrl = ctrl;
  endtask

  task automatic run(input int pulse_at, output int lat, output int stbc);
    int cyc;
    cyc = 0; lat = -1; stbc = 0;
    do begin
      @(negedge clk); #1; cyc++;
      if (cyc == 1) begin
        req = 0;
        req_data = 8'($urandom); cfg_div = 8'($urandom);
        cfg_ctrl = 8'($urandom); req_cfg = 1'($urandom);
      end
      if (cyc == pulse_at) req = 1;
      if (cyc == pulse_at + 1) req = 0;
      if (stb) stbc++;
      if ((done || err) && lat < 0) lat = cyc;
    end while (q.size() > 0 && cyc < 400);
    if (q.size() > 0) begin
      vecs++; fails++;
      $display("FAIL drain: %0d expected cycles left after %0d cycles", q.size(), cyc);
      q.delete();
    end
  endtask

  function automatic int cnt_adr(input logic [7:0] a);
    int c = 0;
    foreach (blog[i]) if (blog[i][15:8] == a) c++;
    return c;
  endfunction

  task automatic plan(input int notdone, input logic [7:0] rx);
    for (int i = 0; i < 16; i++) p_delay[i] = 0;
    p_notdone = notdone; p_rx = rx;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, stbc;
    for (int i = 0; i < 16; i++) p_delay[i] = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stb", stb, 0);
    chk("rst_adr", adr, 0);
    chk("rst_rsp", rsp_data, 0);
    rst = 0;

    // 1: full config path, 1-cycle acks
    plan(0, 8'h3c);
    start(1, 8'ha5, 8'h04, 8'hc1);
    run(0, lat, stbc);
    chk("t1_lat", lat, 10);
    chk("t1_nacc", blog.size(), 5);
    chk("t1_div", blog[0], {1'b1, 8'h01, 8'h04});
    chk("t1_ctrl", blog[1], {1'b1, 8'h00, 8'hc1});
    chk("t1_txd", blog[2], {1'b1, 8'h02, 8'ha5});
    chk("t1_stat", blog[3], {1'b0, 8'h04, 8'h00});
    chk("t1_rxd", blog[4], {1'b0, 8'h03, 8'h00});
    chk("t1_rsp", rsp_data, 8'h3c);

    // 2: no config
    plan(0, 8'h96);
    start(0, 8'h5a, 8'h00, 8'h00);
    run(0, lat, stbc);
    chk("t2_lat", lat, 6);
    chk("t2_nacc", blog.size(), 3);
    chk("t2_txd", blog[0], {1'b1, 8'h02, 8'h5a});
    chk("t2_ndiv", cnt_adr(8'd1) + cnt_adr(8'd0), 0);
    chk("t2_rsp", rsp_data, 8'h96);

    // 3: three not-done polls
    plan(3, 8'h11);
    start(0, 8'h33, 8'h00, 8'h00);
    run(0, lat, stbc);
    chk("t3_nstat", cnt_adr(8'd4), 4);
    chk("t3_lat", lat, 12);
    chk("t3_rsp", rsp_data, 8'h11);

    // 4: TXD never acked, then a normal transfer
    plan(0, 8'hff);
    p_delay[0] = 100;
    start(0, 8'h77, 8'h00, 8'h00);
    run(0, lat, stbc);
    chk("t4_stbc", stbc, 16);
    chk("t4_lat", lat, 17);
    chk("t4_busy", busy, 0);
    chk("t4_rsp_kept", rsp_data, 8'h11);
    plan(0, 8'he7);
    start(0, 8'h12, 8'h00, 8'h00);
    run(0, lat, stbc);
    chk("t4_next_rsp", rsp_data, 8'he7);

    // 5: poll limit with a req pulse while busy
    plan(99, 8'h44);
    start(0, 8'h21, 8'h00, 8'h00);
    run(4, lat, stbc);
    chk("t5_nstat", cnt_adr(8'd4), 4);
    chk("t5_nrxd", cnt_adr(8'd3), 0);
    chk("t5_lat", lat, 10);
    repeat (3) @(negedge clk);
    #1;
    chk("t5_idle", busy, 0);

    // 6: reset mid W_CTRL
    plan(0, 8'h55);
    p_delay[1] = 6;
    start(1, 8'h01, 8'h02, 8'h03);
    @(negedge clk); #1; req = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("t6_in_ctrl", {stb, we, adr}, {1'b1, 1'b1, 32'd0});
    rst = 1; q.delete(); mrsp = '0;
    @(negedge clk); #1;
    chk("t6_stb", stb, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rsp", rsp_data, 0);
    rst = 0;
    plan(1, 8'hc9);
    start(1, 8'h9e, 8'h08, 8'h81);
    run(0, lat, stbc);
    chk("t6_after", rsp_data, 8'hc9);

    // 7: ack arriving in the last allowed cycle completes normally
    plan(0, 8'h6b);
    p_delay[0] = TMO - 1;
    start(0, 8'hd2, 8'h00, 8'h00);
    run(0, lat, stbc);
    chk("t7_stbc", stbc, TMO + 2);
    chk("t7_rsp", rsp_data, 8'h6b);

    // Randomized transfers
    for (int it = 0; it < 40; it++) begin
      plan($urandom_range(0, 5), 8'($urandom));
      for (int i = 0; i < 16; i++)
        p_delay[i] = ($urandom_range(0, 11) == 0) ? 40 : $urandom_range(0, 3);
      p_junk = 8'($urandom);
      p_spur = 1'($urandom);
      start(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      run((it % 3 == 0) ? 5 : 0, lat, stbc);
    end
    p_spur = 0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
